// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants for the capture FIFO write-port arbiter: word width,
// grant-id width and the fixed requester slot assignments.
package fifo_write_arbiter_pkg;

  localparam int unsigned DATA_WIDTH     = 18;
  localparam int unsigned GRANT_ID_WIDTH = 3;

  // Requester slots as wired at the capture frontend.
  localparam int unsigned REQ_USB  = 0;
  localparam int unsigned REQ_TS   = 1;
  localparam int unsigned REQ_MARK = 2;

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// scanning upward and wrapping; returns one-hot grant and its encoded index.
module fifo_write_arbiter_rr_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0]          req_i,
  input  logic [PTR_W-1:0]          ptr_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [GRANT_ID_WIDTH-1:0] idx_o,
  output logic                      any_o
);

  logic [PTR_W-1:0] slot;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    slot    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot = PTR_W'((32'(ptr_i) + i) % N_REQ);
      if (!found && req_i[slot]) begin
        found         = 1'b1;
        grant_o[slot] = 1'b1;
        idx_o         = GRANT_ID_WIDTH'(slot);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the capture FIFO write port between frontend sources: round-robin
// grants, one registered write per cycle, prog-full back-pressure with
// per-requester stall or drop-and-count behaviour.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned pN_REQ          = 3,
  parameter int unsigned pDATA_WIDTH     = DATA_WIDTH,
  parameter int unsigned pDROP_CNT_WIDTH = 16
) (
  input  logic                                fe_clk,
  input  logic                                reset_n,
  input  logic                                I_enable,
  input  logic                                I_fifo_full,
  input  logic                                I_fifo_flush,
  input  logic [pN_REQ-1:0]                   I_req_valid,
  input  logic [pN_REQ*pDATA_WIDTH-1:0]       I_req_data,
  input  logic [pN_REQ-1:0]                   I_req_lossy,
  input  logic                                I_clear_drops,
  output logic [pN_REQ-1:0]                   O_req_ready,
  output logic [pDATA_WIDTH-1:0]              O_fifo_data,
  output logic                                O_fifo_wr,
  output logic [GRANT_ID_WIDTH-1:0]           O_grant_id,
  output logic [pN_REQ*pDROP_CNT_WIDTH-1:0]   O_drop_count,
  output logic                                O_drop_any
);

  localparam int unsigned PTR_W = (pN_REQ > 1) ? $clog2(pN_REQ) : 1;
  localparam logic [pDROP_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic                       wr_q, wr_d;
  logic [pDATA_WIDTH-1:0]     data_q, data_d;
  logic [GRANT_ID_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [pDROP_CNT_WIDTH-1:0] cnt_q [pN_REQ];
  logic [pDROP_CNT_WIDTH-1:0] cnt_d [pN_REQ];
  logic                       drop_any_q, drop_any_d;

  logic                       active;
  logic                       grant_en;
  logic                       drop_en;
  logic [pN_REQ-1:0]          arb_grant;
  logic [GRANT_ID_WIDTH-1:0]  arb_idx;
  logic                       arb_any;
  logic [pN_REQ-1:0]          drop_vec;

  // Flush is indistinguishable from disarm: nothing granted, nothing dropped.
  assign active   = I_enable & ~I_fifo_flush;
  assign grant_en = active & ~I_fifo_full;
  assign drop_en  = active & I_fifo_full;

  fifo_write_arbiter_rr_arbiter #(
    .N_REQ (pN_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i   (I_req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    ptr_d      = ptr_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    grant_id_d = grant_id_q;
    drop_vec   = drop_en ? (I_req_valid & I_req_lossy) : '0;

    if (grant_en && arb_any) begin
      wr_d       = 1'b1;
      grant_id_d = arb_idx;
      for (int k = 0; k < int'(pN_REQ); k++) begin
        if (arb_grant[k]) begin
          data_d = I_req_data[k*pDATA_WIDTH +: pDATA_WIDTH];
          ptr_d  = PTR_W'((k + 1) % int'(pN_REQ));
        end
      end
    end

    O_req_ready = (grant_en ? arb_grant : '0) | drop_vec;

    // Clear first, then count: a drop coincident with a clear leaves 1.
    drop_any_d = (I_clear_drops ? 1'b0 : drop_any_q) | (|drop_vec);
    for (int k = 0; k < int'(pN_REQ); k++) begin
      cnt_d[k] = I_clear_drops ? '0 : cnt_q[k];
      if (drop_vec[k] && (cnt_d[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_d[k] + 1'b1;
      end
      O_drop_count[k*pDROP_CNT_WIDTH +: pDROP_CNT_WIDTH] = cnt_q[k];
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      grant_id_q <= '0;
      drop_any_q <= 1'b0;
      for (int k = 0; k < int'(pN_REQ); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      grant_id_q <= grant_id_d;
      drop_any_q <= drop_any_d;
      for (int k = 0; k < int'(pN_REQ); k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign O_fifo_wr   = wr_q;
  assign O_fifo_data = data_q;
  assign O_grant_id  = grant_id_q;
  assign O_drop_any  = drop_any_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: cycle-by-cycle reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int W  = 18;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           full = 1'b0;
  logic           flush = 1'b0;
  logic [N-1:0]   valid = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   lossy = '0;
  logic           clear = 1'b0;
  logic [N-1:0]   O_req_ready;
  logic [W-1:0]   O_fifo_data;
  logic           O_fifo_wr;
  logic [2:0]     O_grant_id;
  logic [N*CW-1:0] O_drop_count;
  logic           O_drop_any;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (what the registered outputs must be right now).
  int           m_ptr;
  logic         m_wr;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_cnt [N];
  logic         m_any;

  int           obs_ids [$];
  logic [W-1:0] obs_data [$];
  logic [N-1:0] exp_rdy;
  logic         granted;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .pN_REQ          (N),
    .pDATA_WIDTH     (W),
    .pDROP_CNT_WIDTH (CW)
  ) dut (
    .fe_clk        (clk),
    .reset_n       (rst_n),
    .I_enable      (en),
    .I_fifo_full   (full),
    .I_fifo_flush  (flush),
    .I_req_valid   (valid),
    .I_req_data    (data),
    .I_req_lossy   (lossy),
    .I_clear_drops (clear),
    .O_req_ready   (O_req_ready),
    .O_fifo_data   (O_fifo_data),
    .O_fifo_wr     (O_fifo_wr),
    .O_grant_id    (O_grant_id),
    .O_drop_count  (O_drop_count),
    .O_drop_any    (O_drop_any)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare DUT against the model, then advance the model to what the next
  // rising edge must produce from the inputs currently applied.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0; m_wr = 1'b0; m_data = '0; m_id = 0; m_any = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end
    check("fifo_wr", 32'(O_fifo_wr), 32'(m_wr));
    if (m_wr || !rst_n) begin
      check("fifo_data", 32'(O_fifo_data), 32'(m_data));
      check("grant_id", 32'(O_grant_id), 32'(m_id));
    end
    for (int k = 0; k < N; k++)
      check($sformatf("drop_count%0d", k), 32'(O_drop_count[k*CW +: CW]), 32'(m_cnt[k]));
    check("drop_any", 32'(O_drop_any), 32'(m_any));
    if (O_fifo_wr) begin
      obs_ids.push_back(int'(O_grant_id));
      obs_data.push_back(O_fifo_data);
    end

    exp_rdy = '0;
    granted = 1'b0;
    m_wr    = 1'b0;
    if (en && !flush && !full) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!granted && valid[k]) begin
          granted    = 1'b1;
          exp_rdy[k] = 1'b1;
          m_wr       = 1'b1;
          m_data     = data[k*W +: W];
          m_id       = k;
          m_ptr      = (k + 1) % N;
        end
      end
    end
    if (clear) begin
      m_any = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end
    if (en && !flush && full) begin
      for (int k = 0; k < N; k++) begin
        if (valid[k] && lossy[k]) begin
          exp_rdy[k] = 1'b1;
          m_any      = 1'b1;
          if (m_cnt[k] < (1 << CW) - 1) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    check("req_ready", 32'(O_req_ready), 32'(exp_rdy));
  end

  initial begin
    data = {18'h00300, 18'h00200, 18'h00100};
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);

    // Round-robin across three lossless requesters.
    obs_ids.delete(); obs_data.delete();
    en = 1'b1; valid = 3'b111;
    step(7);
    valid = '0;
    step(2);
    check("rr_write_count", 32'(obs_ids.size()), 32'd7);
    if (obs_ids.size() >= 6) begin
      check("rr_id0", 32'(obs_ids[0]), 32'd0);
      check("rr_id1", 32'(obs_ids[1]), 32'd1);
      check("rr_id2", 32'(obs_ids[2]), 32'd2);
      check("rr_id3", 32'(obs_ids[3]), 32'd0);
      check("rr_id4", 32'(obs_ids[4]), 32'd1);
      check("rr_id5", 32'(obs_ids[5]), 32'd2);
      check("rr_data0", 32'(obs_data[0]), 32'h100);
      check("rr_data2", 32'(obs_data[2]), 32'h300);
    end

    // Lossless stall while full, resumes as soon as full drops.
    obs_ids.delete();
    valid[REQ_TS] = 1'b1; full = 1'b1;
    step(5);
    check("stall_ready", 32'(O_req_ready), 32'd0);
    check("stall_count1", 32'(O_drop_count[REQ_TS*CW +: CW]), 32'd0);
    check("stall_no_write", 32'(obs_ids.size()), 32'd0);
    full = 1'b0;
    #1 check("resume_ready", 32'(O_req_ready), 32'b010);
    step(1);
    check("resume_wr", 32'(O_fifo_wr), 32'd1);
    check("resume_id", 32'(O_grant_id), 32'd1);
    check("resume_data", 32'(O_fifo_data), 32'h200);
    valid = '0;
    step(2);

    // Lossy drops on the marker requester.
    obs_ids.delete();
    valid[REQ_MARK] = 1'b1; lossy[REQ_MARK] = 1'b1; full = 1'b1;
    #1 check("lossy_ready", 32'(O_req_ready), 32'b100);
    step(10);
    check("lossy_count2", 32'(O_drop_count[REQ_MARK*CW +: CW]), 32'd10);
    check("lossy_any", 32'(O_drop_any), 32'd1);
    check("lossy_no_write", 32'(obs_ids.size()), 32'd0);
    valid = '0;

    // Saturation and clear interplay on the USB requester.
    clear = 1'b1; step(1); clear = 1'b0;
    check("clear_count2", 32'(O_drop_count[REQ_MARK*CW +: CW]), 32'd0);
    check("clear_any", 32'(O_drop_any), 32'd0);
    valid[REQ_USB] = 1'b1; lossy = 3'b001;
    step(20);
    check("sat_count0", 32'(O_drop_count[REQ_USB*CW +: CW]), 32'd15);
    clear = 1'b1;
    step(1);
    check("clear_drop_count0", 32'(O_drop_count[REQ_USB*CW +: CW]), 32'd1);
    check("clear_drop_any", 32'(O_drop_any), 32'd1);
    valid = '0;
    step(1);
    clear = 1'b0;
    check("clear_alone_count0", 32'(O_drop_count[REQ_USB*CW +: CW]), 32'd0);
    check("clear_alone_any", 32'(O_drop_any), 32'd0);

    // Flush and disarm: nothing consumed, nothing counted.
    obs_ids.delete();
    flush = 1'b1; valid = 3'b111; lossy = 3'b111; full = 1'b1;
    step(4);
    check("flush_ready", 32'(O_req_ready), 32'd0);
    check("flush_counts", 32'(O_drop_count), 32'd0);
    flush = 1'b0; en = 1'b0;
    step(3);
    check("disable_ready", 32'(O_req_ready), 32'd0);
    check("disable_counts", 32'(O_drop_count), 32'd0);
    check("disable_no_write", 32'(obs_ids.size()), 32'd0);

    // Asynchronous reset in the middle of a burst.
    en = 1'b1; full = 1'b0; lossy = '0;
    step(2);
    check("pre_reset_wr", 32'(O_fifo_wr), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset_wr_now", 32'(O_fifo_wr), 32'd0);
    check("reset_id_now", 32'(O_grant_id), 32'd0);
    @(negedge clk); @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);
    check("post_reset_wr", 32'(O_fifo_wr), 32'd1);
    check("post_reset_id", 32'(O_grant_id), 32'd0);
    check("post_reset_data", 32'(O_fifo_data), 32'h100);
    valid = '0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares the single capture FIFO write port (18-bit data + write strobe, fe_clk domain) between several frontend capture sources, e.g. USB packet data, timestamp/status events and pattern-match markers.
- Arbitration is round-robin, one FIFO write per cycle maximum.
- Honours the FIFO programmable-full threshold as back-pressure.
- Per requester, either stalls the source (lossless) or discards its words and counts drops (lossy).
- Sits between the fe_capture_* sources and the capture FIFO write side.

Parameters:
pN_REQ, 3, number of requesters (2..8)
pDATA_WIDTH, 18, FIFO word width
pDROP_CNT_WIDTH, 16, width of each per-requester saturating drop counter

Ports:
fe_clk  input  1  frontend clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
I_enable  input  1  capture arming; 0 = no grants, no drops, all ready low
I_fifo_full  input  1  FIFO programmable-full threshold flag (fe_clk domain)
I_fifo_flush  input  1  flush in progress; treated exactly as I_enable=0
I_req_valid  input  pN_REQ  per-requester word valid
I_req_data  input  pN_REQ*pDATA_WIDTH  per-requester word; requester k at bits [k*W +: W]
I_req_lossy  input  pN_REQ  per-requester policy; 1 = drop when full, 0 = stall when full (quasi-static)
I_clear_drops  input  1  single-cycle pulse; clears all drop counters and O_drop_any
O_req_ready  output  pN_REQ  word consumed this cycle (granted or dropped); combinational
O_fifo_data  output  pDATA_WIDTH  registered write data to FIFO
O_fifo_wr  output  1  registered write strobe to FIFO
O_grant_id  output  3  index of requester written by current O_fifo_wr
O_drop_count  output  pN_REQ*pDROP_CNT_WIDTH  per-requester drop counters
O_drop_any  output  1  sticky OR of all drop events

Behaviour:
- Reset (reset_n=0, asynchronous): O_fifo_wr=0, O_fifo_data=0, O_grant_id=0, all drop counters=0, O_drop_any=0, rr pointer=0.
- Active (I_enable=1, I_fifo_flush=0, I_fifo_full=0):
  - Search valid requesters starting at rr pointer, ascending, wrapping modulo pN_REQ.
  - First hit k: O_req_ready[k]=1 in cycle t; O_fifo_wr=1, O_fifo_data=word k, O_grant_id=k at t+1.
  - rr pointer <= (k+1) mod pN_REQ.
  - Non-granted requesters have ready=0 and hold their word.
- No valid requesters: O_fifo_wr=0 next cycle; pointer unchanged.
- Full (I_fifo_full=1, active):
  - No grant; O_fifo_wr=0 next cycle.
  - Lossy requester with valid=1: ready=1, word discarded, its counter +1, O_drop_any<=1. All lossy requesters drop in the same cycle.
  - Lossless requesters: ready=0 (stall).
  - Pointer unchanged.
- One-cycle registered latency is permitted because the FIFO prog_full threshold leaves at least 4 words of margin below true full.
- Inactive (I_enable=0 or I_fifo_flush=1): all ready=0, O_fifo_wr=0 next cycle, no drops counted, counters held.
- Drop counters:
  - Saturate at 2^pDROP_CNT_WIDTH-1.
  - O_drop_any is set on every drop event, even when the counter is already saturated.
  - I_clear_drops with a simultaneous drop on requester k: counter k=1, others=0, O_drop_any=1.
- I_fifo_full deasserting: grants resume the same cycle.
- I_enable dropping: a word already registered still writes at t+1.
- Reset mid-write: the pending O_fifo_wr is cleared immediately; the word is lost and that loss is not counted.
- O_grant_id width is fixed at 3; upper bits are 0 when pN_REQ<8.

Decomposition:
- defines_pw.v gets:
  - the data-width constant;
  - requester index defines: REQ_USB=0, REQ_TS=1, REQ_MARK=2.
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, encoded index;
  - purely combinational.
- Pointer register, output register and drop counters live in fifo_write_arbiter.

Test Plan:
- Round-robin: all 3 lossless valid continuously with data 0x100/0x200/0x300, full=0 → writes cycle ids 0,1,2,0,1,2…; O_fifo_wr high every cycle after the first.
- Stall: req1 lossless valid, full=1 for 5 cycles → ready1=0, no writes, counter1=0; full=0 → data written next cycle, id=1.
- Lossy drop: req2 lossy valid for 10 cycles while full=1 → ready2=1 each cycle, counter2=10, O_drop_any=1, O_fifo_wr=0 throughout.
- Saturation/clear: pDROP_CNT_WIDTH=4, 20 drops on req0 → counter0=15; I_clear_drops coincident with one drop → counter0=1; next clear alone → 0 and O_drop_any=0.
- Disable/flush: I_fifo_flush=1 with all valid, full=1, lossy=111 → ready=000, no writes, counters unchanged.
- Async reset: assert reset_n=0 mid-burst between clock edges → O_fifo_wr=0 immediately; after release, first grant goes to requester 0.
